// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the transmit frame scheduler.
// Build option TX_SCHED_ERR_EN enables error-report arbitration.
package tx_sched_pkg;

    // TX_SCHED_ERR_EN: when defined, err_req/err_code compete with the FIFO
    // for the UART TX; when undefined they are ignored and err_ack stays 0.

    localparam int TX_SCHED_TIMEOUT_DEF = 4;

    localparam logic [2:0] ENC_IDLE      = 3'd0;
    localparam logic [2:0] ENC_LOAD      = 3'd1;
    localparam logic [2:0] ENC_LAUNCH    = 3'd2;
    localparam logic [2:0] ENC_WAIT_BUSY = 3'd3;
    localparam logic [2:0] ENC_WAIT_DONE = 3'd4;
    localparam logic [2:0] ENC_GAP       = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = ENC_IDLE,
        ST_LOAD      = ENC_LOAD,
        ST_LAUNCH    = ENC_LAUNCH,
        ST_WAIT_BUSY = ENC_WAIT_BUSY,
        ST_WAIT_DONE = ENC_WAIT_DONE,
        ST_GAP       = ENC_GAP
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tx_frame_sched_timer.sv
// Loadable down-counter with zero flag, shared by the gap count
// and the launch-acknowledge timeout.
module tx_sched_timer #(
    parameter int W = 4
) (
    input  logic         tx_clk,
    input  logic         uart_sync_rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge tx_clk or negedge uart_sync_rst) begin
        if (!uart_sync_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tx_frame_sched.sv
// Transmit frame scheduler: FIFO/error-report arbitration, launch,
// acknowledge timeout and inter-frame gap. Option: TX_SCHED_ERR_EN.
module tx_frame_sched
    import tx_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int GAP_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = TX_SCHED_TIMEOUT_DEF,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                  tx_clk,
    input  logic                  uart_sync_rst,
    input  logic                  sched_enable,
    input  logic [GAP_WIDTH-1:0]  frame_gap,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_inc,
    input  logic                  err_req,
    input  logic [DATA_WIDTH-1:0] err_code,
    output logic                  err_ack,
    input  logic                  tx_busy,
    output logic [DATA_WIDTH-1:0] tx_p_data,
    output logic                  tx_data_valid,
    output logic                  sched_busy,
    output logic                  timeout_flag,
    output logic [CNT_WIDTH-1:0]  frame_cnt
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TW   = max_int(GAP_WIDTH, TO_W);

    // Loaded in LOAD so the window covers LAUNCH plus the WAIT_BUSY cycles.
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    state_t                state_q;
    state_t                state_d;
    logic                  src_err_q;
    logic                  fifo_rd_inc_q;
    logic                  err_ack_q;
    logic                  tx_data_valid_q;
    logic                  sched_busy_q;
    logic                  timeout_q;
    logic [DATA_WIDTH-1:0] tx_p_data_q;
    logic [CNT_WIDTH-1:0]  frame_cnt_q;

    logic                  err_sel;
    logic                  grant;
    logic                  to_hit;
    logic                  done_hit;
    logic                  tmr_load;
    logic [TW-1:0]         tmr_val;
    logic                  tmr_en;
    logic [TW-1:0]         tmr_cnt;
    logic                  tmr_zero;
    logic [TW-1:0]         gap_ext;

`ifdef TX_SCHED_ERR_EN
    // The FIFO wins only right after an error grant, so neither side starves.
    assign err_sel = err_req && !(src_err_q && !fifo_empty);
`else
    logic unused_err;
    assign unused_err = err_req;
    assign err_sel    = 1'b0;
`endif

    assign grant   = sched_enable && (!fifo_empty || err_sel);
    assign gap_ext = TW'(frame_gap);

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
        to_hit   = 1'b0;
        done_hit = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d  = ST_LAUNCH;
                tmr_load = 1'b1;
                tmr_val  = TO_LOAD;
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_BUSY;
                tmr_en  = 1'b1;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmr_zero) begin
                    state_d  = ST_GAP;
                    to_hit   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = gap_ext;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d  = ST_GAP;
                    done_hit = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = gap_ext;
                end
            end
            ST_GAP: begin
                // Exit on 1 or 0 so the gap lasts max(frame_gap,1) cycles.
                if (tmr_zero || (tmr_cnt == TW'(1))) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge tx_clk or negedge uart_sync_rst) begin
        if (!uart_sync_rst) begin
            state_q         <= ST_IDLE;
            src_err_q       <= 1'b0;
            fifo_rd_inc_q   <= 1'b0;
            err_ack_q       <= 1'b0;
            tx_data_valid_q <= 1'b0;
            sched_busy_q    <= 1'b0;
            timeout_q       <= 1'b0;
            tx_p_data_q     <= '0;
            frame_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            sched_busy_q    <= (state_d != ST_IDLE);
            fifo_rd_inc_q   <= 1'b0;
            err_ack_q       <= 1'b0;
            tx_data_valid_q <= 1'b0;
            if ((state_q == ST_IDLE) && grant) begin
                src_err_q     <= err_sel;
                fifo_rd_inc_q <= !err_sel;
                err_ack_q     <= err_sel;
                tx_p_data_q   <= err_sel ? err_code : fifo_rd_data;
            end
            if (state_q == ST_LOAD) begin
                tx_data_valid_q <= 1'b1;
            end
            if (to_hit) begin
                timeout_q <= 1'b1;
            end
            if (done_hit) begin
                frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    tx_sched_timer #(
        .W(TW)
    ) u_timer (
        .tx_clk        (tx_clk),
        .uart_sync_rst (uart_sync_rst),
        .load_i        (tmr_load),
        .load_val_i    (tmr_val),
        .en_i          (tmr_en),
        .cnt_o         (tmr_cnt),
        .zero_o        (tmr_zero)
    );

    assign fifo_rd_inc   = fifo_rd_inc_q;
    assign err_ack       = err_ack_q;
    assign tx_data_valid = tx_data_valid_q;
    assign tx_p_data     = tx_p_data_q;
    assign sched_busy    = sched_busy_q;
    assign timeout_flag  = timeout_q;
    assign frame_cnt     = frame_cnt_q;

endmodule
